// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared FSM state type, hex glyph table and blanking patterns for the scanner.
package seven_seg_pkg;
  typedef enum logic {BLANK, SHOW} state_t;
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
  localparam logic [15:0][6:0] GLYPHS = {GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
                                         GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: digit values, controls and display drive of the scanner.
interface seven_seg_scanner_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] AplusB;
  logic [3:0] AminusB;
  logic [3:0] digit_en;
  logic       freeze;
  logic [3:0] anode;
  logic [6:0] segs;
  logic [1:0] digit_sel;
  logic       frame_tick;
  modport master (output A, B, AplusB, AminusB, digit_en, freeze,
                  input anode, segs, digit_sel, frame_tick);
  modport slave (input A, B, AplusB, AminusB, digit_en, freeze,
                 output anode, segs, digit_sel, frame_tick);
endinterface

// File: rtl/seven_seg_scanner_hex_to_segs.sv
// hex_to_segs: combinational hex nibble to active-low GFEDCBA glyph lookup.
module hex_to_segs
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);
  assign segs = GLYPHS[hex];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit hex display with guard blanking and frame snapshots.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIV_WIDTH    = 17,
  parameter int BLANK_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  seven_seg_scanner_if.slave bus
);
  logic [DIV_WIDTH-1:0] presc, blank_cnt, blank_cnt_nxt;
  logic [1:0] sel, sel_nxt;
  state_t state, state_nxt;
  logic [3:0][3:0] snap, snap_nxt;
  logic tick, frame_end, show_nxt;
  logic [6:0] glyph;
  logic [3:0] anode_nxt;
  logic [6:0] segs_nxt;
  assign tick = &presc;
  assign frame_end = tick && sel == 2'd3;
  always_comb begin
    state_nxt = state;
    blank_cnt_nxt = blank_cnt;
    sel_nxt = sel;
    if (tick) begin
      state_nxt = BLANK;
      blank_cnt_nxt = '0;
      sel_nxt = sel + 2'd1;
    end else if (state == BLANK) begin
      if (blank_cnt == DIV_WIDTH'(BLANK_CYCLES - 1)) state_nxt = SHOW;
      else blank_cnt_nxt = blank_cnt + 1'b1;
    end
  end
  assign snap_nxt = (frame_end && !bus.freeze) ? {bus.AminusB, bus.AplusB, bus.B, bus.A} : snap;
  // Outputs are computed from next-state values so the registered drive lines up with the state it reflects.
  hex_to_segs u_hex (.hex(snap_nxt[sel_nxt]), .segs(glyph));
  always_comb begin
    show_nxt = state_nxt == SHOW && bus.digit_en[sel_nxt];
    anode_nxt = show_nxt ? ~(4'b0001 << sel_nxt) : ANODE_OFF;
    segs_nxt = show_nxt ? glyph : SEG_BLANK;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      blank_cnt <= '0;
      sel <= '0;
      state <= BLANK;
      snap <= '0;
      bus.anode <= ANODE_OFF;
      bus.segs <= SEG_BLANK;
      bus.frame_tick <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      blank_cnt <= blank_cnt_nxt;
      sel <= sel_nxt;
      state <= state_nxt;
      snap <= snap_nxt;
      bus.anode <= anode_nxt;
      bus.segs <= segs_nxt;
      bus.frame_tick <= frame_end;
    end
  end
  assign bus.digit_sel = sel;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized stimulus checked every cycle against an arithmetic scan model.
module tb_seven_seg_scanner;
  localparam int DW = 3;
  localparam int BC = 2;
  localparam int P = 1 << DW;
  logic clk = 1'b0;
  logic reset = 1'b1;
  seven_seg_scanner_if bus ();
  seven_seg_scanner #(.DIV_WIDTH(DW), .BLANK_CYCLES(BC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  bit valid = 0;
  logic [3:0] msnap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] men = 4'hF;
  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at n=%0d: got %b expected %b", name, n, got, exp);
    end
  endtask
  // Model: n counts edges since the last reset edge; everything follows from n and sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      msnap = '{4'd0, 4'd0, 4'd0, 4'd0};
      valid = 1;
    end else begin
      n++;
      if (n % (4 * P) == 0 && !bus.freeze) msnap = '{bus.A, bus.B, bus.AplusB, bus.AminusB};
    end
    men = bus.digit_en;
  end
  always @(negedge clk) if (valid) begin
    int d;
    bit on;
    logic [3:0] ea;
    d = (n / P) % 4;
    on = (n % P) >= BC && men[d];
    ea = on ? ~(4'b0001 << d) : 4'b1111;
    chk("anode", 7'(bus.anode), 7'(ea));
    chk("segs", bus.segs, on ? gl[msnap[d]] : 7'b1111111);
    chk("digit_sel", 7'(bus.digit_sel), 7'(d));
    chk("frame_tick", 7'(bus.frame_tick), 7'(n > 0 && n % (4 * P) == 0));
  end
  task automatic wait_n(input int target);
    int k = 0;
    while (n != target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_n_reached", 7'(n == target), 7'd1);
  endtask
  initial begin
    bus.A = 4'h5; bus.B = 4'h6; bus.AplusB = 4'hB; bus.AminusB = 4'hF;
    bus.digit_en = 4'hF; bus.freeze = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_n(1);  chk("lit_blank1", 7'(bus.anode), 7'(4'b1111));
    wait_n(2);  chk("lit_show0_anode", 7'(bus.anode), 7'(4'b1110));
                chk("lit_show0_segs", bus.segs, 7'b1000000);
    wait_n(7);  chk("lit_show0_end", 7'(bus.anode), 7'(4'b1110));
    wait_n(8);  chk("lit_d1_blank", 7'(bus.anode), 7'(4'b1111));
                chk("lit_d1_sel", 7'(bus.digit_sel), 7'd1);
    wait_n(32); chk("lit_frame_tick", 7'(bus.frame_tick), 7'd1);
    wait_n(34); chk("lit_a5", bus.segs, 7'b0010010);
    bus.A = 4'h3;
    wait_n(58); chk("lit_d3_anode", 7'(bus.anode), 7'(4'b0111));
                chk("lit_d3_f", bus.segs, 7'b0001110);
    wait_n(66); chk("lit_a3", bus.segs, 7'b0110000);
    wait_n(70); bus.A = 4'h9;
    wait_n(71); chk("lit_a3_hold", bus.segs, 7'b0110000);
    wait_n(98); chk("lit_a9", bus.segs, 7'b0010000);
    bus.freeze = 1'b1; bus.A = 4'hE;
    wait_n(130); chk("lit_frozen", bus.segs, 7'b0010000);
    bus.freeze = 1'b0;
    wait_n(162); chk("lit_unfrozen", bus.segs, 7'b0000110);
    bus.digit_en = 4'b1010;
    wait_n(200);
    for (int k = 0; k < 100 && n % 32 != 19; k++) @(negedge clk);
    chk("lit_at_d2_show", 7'(bus.anode), 7'(4'b1111));
    bus.digit_en = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("lit_rst_anode", 7'(bus.anode), 7'(4'b1111));
    chk("lit_rst_segs", bus.segs, 7'b1111111);
    chk("lit_rst_sel", 7'(bus.digit_sel), 7'd0);
    reset = 1'b0;
    wait_n(1); chk("lit_rec_blank", 7'(bus.anode), 7'(4'b1111));
    wait_n(2); chk("lit_rec_show", 7'(bus.anode), 7'(4'b1110));
               chk("lit_rec_zero", bus.segs, 7'b1000000);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) bus.A = 4'($urandom);
      if ($urandom_range(7) == 0) bus.B = 4'($urandom);
      if ($urandom_range(7) == 0) bus.AplusB = 4'($urandom);
      if ($urandom_range(7) == 0) bus.AminusB = 4'($urandom);
      if ($urandom_range(40) == 0) bus.freeze = ~bus.freeze;
      if ($urandom_range(60) == 0) bus.digit_en = 4'($urandom);
      reset = ($urandom_range(500) == 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
